// File: rtl/csa_stream_if.sv
// Stream bus for csa_stream_accumulator: operand beats in, resolved frame total out.
// The design uses the slave modport; the producer/consumer side uses master.
interface csa_stream_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  localparam int ACC_W = WIDTH + 2 + CNT_W;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic [CNT_W-1:0] beats;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, c, in_last, out_ready,
    output in_ready, out_valid, result, beats, ovf
  );

  modport master (
    output in_valid, a, b, c, in_last, out_ready,
    input  in_ready, out_valid, result, beats, ovf
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Frame accumulator: folds three operands per beat into a redundant sum/carry pair and
// performs one carry-propagate add per frame. Carry is kept at half weight (total = sum + 2*carry).
module csa_stream_accumulator #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  csa_stream_if.slave   s
);
  localparam int ACC_W = WIDTH + 2 + CNT_W;
  localparam logic [CNT_W-1:0] BEATS_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [ACC_W-1:0] sum_q,    sum_d;
  logic [ACC_W-1:0] carry_q,  carry_d;
  logic [CNT_W-1:0] beats_q,  beats_d;
  logic             ovf_q,    ovf_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic [ACC_W-1:0] s1_s, c1_s, s2_s, c2_s, s3_s, c3_s;
  logic             in_ready_s;
  logic             out_valid_s;

  // Bitwise full-adder row; the returned carry half carries weight 2.
  function automatic logic [2*ACC_W-1:0] csa3(
    input logic [ACC_W-1:0] x,
    input logic [ACC_W-1:0] y,
    input logic [ACC_W-1:0] z
  );
    logic [ACC_W-1:0] sm;
    logic [ACC_W-1:0] cy;
    sm = x ^ y ^ z;
    cy = (x & y) | (x & z) | (y & z);
    return {cy, sm};
  endfunction

  // 5:2 reduction of (sum, 2*carry, a, b, c) as three chained 3:2 rows.
  always_comb begin
    {c1_s, s1_s} = csa3(sum_q, carry_q << 1, ACC_W'(s.a));
    {c2_s, s2_s} = csa3(s1_s, c1_s << 1, ACC_W'(s.b));
    {c3_s, s3_s} = csa3(s2_s, c2_s << 1, ACC_W'(s.c));
  end

  // Next-state and datapath update; clr overrides every state.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    beats_d  = beats_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    if (clr) begin
      state_d = ST_ACCUM;
      sum_d   = '0;
      carry_d = '0;
      beats_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (s.in_valid) begin
            sum_d   = s3_s;
            carry_d = c3_s;
            if (beats_q == BEATS_MAX) begin
              ovf_d = 1'b1;
            end else begin
              beats_d = beats_q + CNT_W'(1);
            end
            if (s.in_last) begin
              state_d = ST_RESOLVE;
            end else begin
              state_d = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_RESOLVE: begin
          result_d = sum_q + (carry_q << 1);
          state_d  = ST_HOLD;
        end
        ST_HOLD: begin
          // Held beats/ovf are published until the consumer takes the result.
          if (s.out_ready) begin
            state_d = ST_ACCUM;
            sum_d   = '0;
            carry_d = '0;
            beats_d = '0;
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          carry_d = '0;
          beats_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      sum_q    <= '0;
      carry_q  <= '0;
      beats_q  <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      beats_q  <= beats_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  // Handshake flags decode the state register only, never the inputs.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_q)
      ST_ACCUM:   in_ready_s  = 1'b1;
      ST_RESOLVE: in_ready_s  = 1'b0;
      ST_HOLD:    out_valid_s = 1'b1;
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign s.in_ready  = in_ready_s;
  assign s.out_valid = out_valid_s;
  assign s.result    = result_q;
  assign s.beats     = beats_q;
  assign s.ovf       = ovf_q;
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator: integer frame model checked every cycle,
// plus hand-computed expectations for each directed frame.
module tb_csa_stream_accumulator;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int ACC_W = WIDTH + 2 + CNT_W;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  bit   cmp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  csa_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  csa_stream_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .s   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: phase 0 = accepting beats, 1 = resolving, 2 = result offered.
  int   m_phase;
  int   m_total;
  int   m_beats;
  logic m_ovf;
  int   m_result;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_total <= 0; m_beats <= 0; m_ovf <= 1'b0; m_result <= 0;
    end else if (clr) begin
      m_phase <= 0; m_total <= 0; m_beats <= 0; m_ovf <= 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
          m_total <= m_total + int'(bus.a) + int'(bus.b) + int'(bus.c);
          if (m_beats == 15) m_ovf <= 1'b1;
          else m_beats <= m_beats + 1;
          if (bus.in_last) m_phase <= 1;
        end
        1: begin
          m_result <= m_total % (1 << ACC_W);
          m_phase  <= 2;
        end
        2: if (bus.out_ready) begin
          m_phase <= 0; m_total <= 0; m_beats <= 0; m_ovf <= 1'b0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en && !rst) begin
      chk("model_out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      chk("model_in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
      if (m_phase == 2) begin
        chk("model_result", 32'(bus.result), 32'(m_result));
        chk("model_beats", 32'(bus.beats), 32'(m_beats));
        chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
      end
    end
  end

  // Present one beat at a falling edge and hold it until it is taken.
  task automatic beat(input int va, input int vb, input int vc, input logic last);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.a = 4'(va); bus.b = 4'(vb); bus.c = 4'(vc);
    bus.in_last = last;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("beat_accept_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name, input int res, input int nb, input int ov,
                               input bit consume);
    int t;
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_result"}, 32'(bus.result), 32'(res));
    chk({name, "_beats"}, 32'(bus.beats), 32'(nb));
    chk({name, "_ovf"}, 32'(bus.ovf), 32'(ov));
    if (consume) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low;
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_result", 32'(bus.result), 32'd0);
    chk("reset_beats", 32'(bus.beats), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // 1: single beat of maximal operands
    beat(15, 15, 15, 1'b1);
    chk("t1_valid_after_accept", 32'(bus.out_valid), 32'd0);
    chk("t1_ready_in_resolve", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t1_valid_next_edge", 32'(bus.out_valid), 32'd1);
    expect_result("t1", 45, 1, 0, 1'b1);

    // 2: three back-to-back beats; consumer always ready
    bus.out_ready = 1'b1;
    beat(1, 2, 3, 1'b0);
    beat(4, 5, 6, 1'b0);
    beat(7, 8, 9, 1'b1);
    low = 0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.in_ready) low++;
      if (bus.out_valid) begin
        chk("t2_result", 32'(bus.result), 32'd45);
        chk("t2_beats", 32'(bus.beats), 32'd3);
      end
      @(negedge clk);
    end
    chk("t2_ready_low_cycles", 32'(low), 32'd2);
    bus.out_ready = 1'b0;

    // 3: backpressure with a producer pushing beats the whole time
    beat(9, 9, 9, 1'b1);
    expect_result("t3_first", 27, 1, 0, 1'b0);
    bus.in_valid = 1'b1; bus.a = 4'd1; bus.b = 4'd0; bus.c = 4'd0; bus.in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(bus.in_ready), 32'd0);
      chk("t3_stall_result", 32'(bus.result), 32'd27);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    beat(2, 2, 2, 1'b1);
    expect_result("t3_next", 6, 1, 0, 1'b1);

    // 4a: clr mid-frame drops the partial sum and the beat presented with it
    beat(15, 15, 15, 1'b0);
    beat(15, 15, 15, 1'b0);
    clr = 1'b1;
    bus.in_valid = 1'b1; bus.a = 4'd5; bus.b = 4'd5; bus.c = 4'd5; bus.in_last = 1'b1;
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    beat(1, 1, 1, 1'b1);
    expect_result("t4a", 3, 1, 0, 1'b1);

    // 4b: clr in HOLD beats out_ready
    beat(4, 4, 4, 1'b1);
    expect_result("t4b_held", 12, 1, 0, 1'b0);
    clr = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0; bus.out_ready = 1'b0;
    chk("t4b_valid_dropped", 32'(bus.out_valid), 32'd0);
    chk("t4b_ready_back", 32'(bus.in_ready), 32'd1);
    beat(1, 0, 0, 1'b1);
    expect_result("t4b_next", 1, 1, 0, 1'b1);

    // 5: beat-counter saturation and sticky overflow
    for (int i = 1; i <= 16; i++) beat(15, 15, 15, (i == 16) ? 1'b1 : 1'b0);
    expect_result("t5_sat", 720, 15, 1, 1'b1);
    beat(2, 0, 0, 1'b1);
    expect_result("t5_next", 2, 1, 0, 1'b1);

    // 6: asynchronous reset between edges while a result is held
    beat(5, 5, 5, 1'b0);
    beat(6, 6, 6, 1'b1);
    expect_result("t6_pre", 33, 2, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_async_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    beat(3, 3, 3, 1'b1);
    expect_result("t6_after", 9, 1, 0, 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
